// File: rtl/wseq_pkg.sv
// ============================================================================
// Module : wseq_pkg
// Brief  : Shared mode codes and FSM state type for the wave sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wseq_pkg;

    localparam logic [2:0] WSEQ_MODE_TRI_ALT  = 3'd0;
    localparam logic [2:0] WSEQ_MODE_SINE     = 3'd1;
    localparam logic [2:0] WSEQ_MODE_SQUARE   = 3'd2;
    localparam logic [2:0] WSEQ_MODE_TRIANGLE = 3'd3;
    localparam logic [2:0] WSEQ_MODE_SAW      = 3'd4;
    localparam logic [2:0] WSEQ_MODE_ABS_SINE = 3'd5;
    localparam logic [2:0] WSEQ_MODE_SINE_ALT = 3'd6;
    localparam logic [2:0] WSEQ_MODE_IDLE     = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } wseq_state_e;

endpackage

`default_nettype wire

// File: rtl/wseq_table.sv
// ============================================================================
// Module : wseq_table
// Brief  : DEPTH x (mode, length) register file; sync write, async read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wseq_table
    import wseq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [2:0]       wr_mode,
    input  logic [LEN_W-1:0] wr_len,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [2:0]       rd_mode,
    output logic [LEN_W-1:0] rd_len
);

    logic [2:0]       r_mode [DEPTH];
    logic [LEN_W-1:0] r_len  [DEPTH];

    // Cleared entries read as a zero-length idle segment, so they are skipped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mode[i] <= WSEQ_MODE_IDLE;
                r_len[i]  <= '0;
            end
        end else if (wr_en) begin
            r_mode[wr_addr] <= wr_mode;
            r_len[wr_addr]  <= wr_len;
        end
    end

    assign rd_mode = r_mode[rd_addr];
    assign rd_len  = r_len[rd_addr];

endmodule

`default_nettype wire

// File: rtl/wave_sequencer.sv
// ============================================================================
// Module : wave_sequencer
// Brief  : Plays a table of (mode, length) segments onto the generator select,
//          with one idle-code cycle between segments. WSEQ_LOOP_EN adds `loop`.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wave_sequencer
    import wseq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [2:0]       wr_mode,
    input  logic [LEN_W-1:0] wr_len,
    output logic             wr_err,
    input  logic             start,
    input  logic             stop,
    input  logic [IDX_W:0]   seg_cnt,
`ifdef WSEQ_LOOP_EN
    input  logic             loop,
`endif
    output logic [2:0]       status,
    output logic [IDX_W-1:0] seg_idx,
    output logic             seg_first,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W:0] c_depth = (IDX_W+1)'(DEPTH);

    wseq_state_e      r_state, w_state_nx;
    logic [IDX_W:0]   r_count, w_count_nx, w_cnt_clamp;
    logic [LEN_W-1:0] r_len_cnt, w_len_cnt_nx;
    logic [IDX_W-1:0] w_idx_nx;
    logic [2:0]       w_rd_mode, w_status_nx;
    logic [LEN_W-1:0] w_rd_len;
    logic             w_loop, w_last_seg, w_seg_end;

`ifdef WSEQ_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    wseq_table #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && (r_state == IDLE)),
        .wr_addr (wr_addr),
        .wr_mode (wr_mode),
        .wr_len  (wr_len),
        .rd_addr (seg_idx),
        .rd_mode (w_rd_mode),
        .rd_len  (w_rd_len)
    );

    assign w_cnt_clamp = (seg_cnt > c_depth) ? c_depth : seg_cnt;
    assign w_last_seg  = (({1'b0, seg_idx} + 1'b1) == r_count);

    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = seg_idx;
        w_count_nx   = r_count;
        w_len_cnt_nx = r_len_cnt;
        w_seg_end    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_count_nx = w_cnt_clamp;
                    w_idx_nx   = '0;
                    w_state_nx = (w_cnt_clamp == '0) ? FIN : GAP;
                end
            end
            GAP: begin
                if (stop) begin
                    w_state_nx = IDLE;
                    w_idx_nx   = '0;
                end else if (w_rd_len != '0) begin
                    w_state_nx   = RUN;
                    w_len_cnt_nx = w_rd_len;
                end else begin
                    w_seg_end = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_nx = IDLE;
                    w_idx_nx   = '0;
                end else begin
                    w_len_cnt_nx = r_len_cnt - 1'b1;
                    w_seg_end    = (r_len_cnt == LEN_W'(1));
                end
            end
            FIN: begin
                w_state_nx = IDLE;
                w_idx_nx   = '0;
            end
            default: begin
                w_state_nx = IDLE;
                w_idx_nx   = '0;
            end
        endcase

        if (w_seg_end) begin
            if (!w_last_seg) begin
                w_idx_nx   = seg_idx + 1'b1;
                w_state_nx = GAP;
            end else if (w_loop) begin
                w_idx_nx   = '0;
                w_state_nx = GAP;
            end else begin
                w_state_nx = FIN;
            end
        end

        // RUN is only entered or held with an unchanged index, so the current read is valid.
        w_status_nx = (w_state_nx == RUN) ? w_rd_mode : WSEQ_MODE_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_len_cnt <= '0;
            seg_idx   <= '0;
            status    <= WSEQ_MODE_IDLE;
            seg_first <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_len_cnt <= w_len_cnt_nx;
            seg_idx   <= w_idx_nx;
            status    <= w_status_nx;
            seg_first <= (w_state_nx == RUN) && (r_state == GAP);
            busy      <= (w_state_nx != IDLE);
            done      <= (w_state_nx == FIN);
            wr_err    <= wr_en && (r_state != IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wave_sequencer.sv
// ============================================================================
// Module : tb_wave_sequencer
// Brief  : Randomized self-checking bench with a per-cycle trace model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wave_sequencer;

    localparam int DEPTH = 8;
    localparam int LEN_W = 16;
    localparam int IDX_W = 3;
    localparam logic [6:0] c_idle_flags = 7'b111_0_0_0_0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    logic [2:0]       wr_mode;
    logic [LEN_W-1:0] wr_len;
    logic             wr_err;
    logic             start;
    logic             stop;
    logic [IDX_W:0]   seg_cnt;
    logic             loop;
    logic [2:0]       status;
    logic [IDX_W-1:0] seg_idx;
    logic             seg_first;
    logic             busy;
    logic             done;

    wave_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_mode   (wr_mode),
        .wr_len    (wr_len),
        .wr_err    (wr_err),
        .start     (start),
        .stop      (stop),
        .seg_cnt   (seg_cnt),
`ifdef WSEQ_LOOP_EN
        .loop      (loop),
`endif
        .status    (status),
        .seg_idx   (seg_idx),
        .seg_first (seg_first),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] flags;   // {status, seg_first, busy, done, wr_err}
        int         idx;     // -1: index not checked
    } exp_t;

    exp_t exp_q[$];
    int   m_mode [DEPTH];
    int   m_len  [DEPTH];
    int   n_checks = 0;
    int   n_fail   = 0;

    wire [6:0] dut_flags = {status, seg_first, busy, done, wr_err};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input int st, input bit first, input bit fin, input int idx);
        exp_t e;
        e.flags = {st[2:0], first, 1'b1, fin, 1'b0};
        e.idx   = idx;
        exp_q.push_back(e);
    endfunction

    // Expected busy-period trace: per segment one idle gap then L cycles of its mode.
    function automatic int build(input int cnt, input int passes);
        int c, per_pass;
        c = (cnt > DEPTH) ? DEPTH : cnt;
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < c; i++) begin
                push(7, 1'b0, 1'b0, i);
                for (int k = 0; k < m_len[i]; k++)
                    push(m_mode[i], k == 0, 1'b0, i);
            end
        end
        per_pass = (passes > 0) ? exp_q.size() / passes : 0;
        push(7, 1'b0, 1'b1, -1);
        return per_pass;
    endfunction

    task automatic write_entry(input int addr, input int mode, input int len);
        wr_en   = 1'b1;
        wr_addr = addr[IDX_W-1:0];
        wr_mode = mode[2:0];
        wr_len  = len[LEN_W-1:0];
        m_mode[addr] = mode;
        m_len[addr]  = len;
        step();
        wr_en = 1'b0;
        check_eq("wr_idle_no_err", {31'b0, wr_err}, 32'd0);
    endtask

    // stop_at / wr_at: cycle index of the trace after which to act; -1 none, -2 random.
    task automatic run_seq(input int cnt, input int stop_at_in, input int wr_at_in, input int passes);
        int per_pass, sz, stop_at, wr_at;
        per_pass = build(cnt, passes);
        sz = exp_q.size();
        stop_at = (stop_at_in == -2) ? $urandom_range(0, sz - 1) : stop_at_in;
        wr_at   = wr_at_in;
        if (wr_at == -2) wr_at = (sz >= 2) ? $urandom_range(0, sz - 2) : -1;
        if (stop_at >= 0) wr_at = -1;
        if (wr_at >= 0) exp_q[wr_at + 1].flags[0] = 1'b1;

        seg_cnt = cnt[IDX_W:0];
        start   = 1'b1;
        stop    = 1'b0;
        step();
        start   = 1'b0;
        for (int i = 0; i < sz; i++) begin
            check_eq("trace_flags", {25'b0, dut_flags}, {25'b0, exp_q[i].flags});
            if (exp_q[i].idx >= 0)
                check_eq("trace_idx", {29'b0, seg_idx}, exp_q[i].idx);
            wr_en = 1'b0;
            start = (i < sz - 1) && ($urandom_range(0, 3) == 0);
            if (passes > 1 && i == (passes - 1) * per_pass) loop = 1'b0;
            if (i == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = IDX_W'($urandom_range(0, DEPTH - 1));
                wr_mode = 3'($urandom_range(0, 7));
                wr_len  = LEN_W'($urandom_range(1, 9));
            end
            if (i == stop_at) begin
                stop = 1'b1;
                step();
                stop  = 1'b0;
                start = 1'b0;
                check_eq("stop_idle", {25'b0, dut_flags}, {25'b0, c_idle_flags});
                return;
            end
            step();
        end
        wr_en = 1'b0;
        start = 1'b0;
        check_eq("end_idle", {25'b0, dut_flags}, {25'b0, c_idle_flags});
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_mode = '0; wr_len = '0;
        start = 1'b0; stop = 1'b0; seg_cnt = '0; loop = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin m_mode[i] = 7; m_len[i] = 0; end
        step(); step();
        check_eq("reset_flags", {25'b0, dut_flags}, {25'b0, c_idle_flags});
        check_eq("reset_idx", {29'b0, seg_idx}, 32'd0);
        rst_n = 1'b1;

        // Cleared table: every entry is a zero-length skip.
        run_seq(8, -1, -1, 1);

        // Two SINE segments: 7,1,1,1,7,1,1,7(done).
        write_entry(0, 1, 3);
        write_entry(1, 1, 2);
        run_seq(2, -1, -1, 1);

        // Zero-length middle segment.
        write_entry(0, 2, 1);
        write_entry(1, 5, 0);
        write_entry(2, 3, 2);
        run_seq(3, -1, -1, 1);

        // Empty sequence goes straight to FIN.
        run_seq(0, -1, -1, 1);

        // Stop on the second RUN cycle of segment 0, then a clean restart.
        write_entry(0, 4, 3);
        run_seq(2, 2, -1, 1);
        run_seq(2, -1, -1, 1);

        // Rejected write while busy; table must be intact on the rerun.
        run_seq(3, -1, 2, 1);
        run_seq(3, -1, -1, 1);

        // start and stop together in IDLE: stop wins.
        seg_cnt = 4'd2; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_eq("start_stop_idle", {25'b0, dut_flags}, {25'b0, c_idle_flags});
        step();
        check_eq("start_stop_idle2", {25'b0, dut_flags}, {25'b0, c_idle_flags});

        // Count above DEPTH clamps to the full table.
        run_seq(12, -1, -1, 1);

`ifdef WSEQ_LOOP_EN
        write_entry(0, 2, 1);
        write_entry(1, 6, 1);
        loop = 1'b1;
        run_seq(2, -1, -1, 3);
        loop = 1'b0;
`endif

        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                write_entry($urandom_range(0, DEPTH - 1), $urandom_range(0, 7), $urandom_range(0, 4));
            run_seq($urandom_range(0, 11), ($urandom_range(0, 3) == 0) ? -2 : -1,
                    ($urandom_range(0, 2) == 0) ? -2 : -1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
